// File: rtl/c7b_axi_sram_slave.sv
// c7b_axi_sram_slave: AXI4 responder over a word-addressed on-chip SRAM.
// Optional C7B_AXI_SLV_STALL_EN adds LFSR-driven back-pressure.
module c7b_axi_sram_slave #(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LATENCY  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_ar_valid,
   output logic        s_ar_ready,
   input  logic [3:0]  s_ar_id,
   input  logic [31:0] s_ar_addr,
   input  logic [7:0]  s_ar_len,
   input  logic [2:0]  s_ar_size,
   input  logic [1:0]  s_ar_burst,
   output logic        s_r_valid,
   input  logic        s_r_ready,
   output logic [3:0]  s_r_id,
   output logic [31:0] s_r_data,
   output logic [1:0]  s_r_resp,
   output logic        s_r_last,
   input  logic        s_aw_valid,
   output logic        s_aw_ready,
   input  logic [3:0]  s_aw_id,
   input  logic [31:0] s_aw_addr,
   input  logic [7:0]  s_aw_len,
   input  logic [2:0]  s_aw_size,
   input  logic [1:0]  s_aw_burst,
   input  logic        s_w_valid,
   output logic        s_w_ready,
   input  logic [31:0] s_w_data,
   input  logic [3:0]  s_w_strb,
   input  logic        s_w_last,
   output logic        s_b_valid,
   input  logic        s_b_ready,
   output logic [3:0]  s_b_id,
   output logic [1:0]  s_b_resp
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [7:0] LAT_INIT = 8'(RD_LATENCY - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH_WORDS];

   function automatic logic in_range(input logic [31:0] a);
      return {1'b0, a} < LIMIT;
   endfunction

   // WRAP keeps the upper bits and lets the low bits roll within the burst
   function automatic logic [31:0] next_addr(input logic [31:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step, mask;
      step = 32'd1 << size;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      if (len > 8'd15) return a + step;
      if (burst == 2'b00) return a;
      if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 ||
          len == 8'd7 || len == 8'd15))
         return (a & ~mask) | ((a + step) & mask);
      return a + step;
   endfunction

   r_state_t    r_state, r_nxt;
   logic [3:0]  r_id_q;
   logic [31:0] r_addr, r_ld_addr, r_data_q;
   logic [7:0]  r_len, r_beat, r_lat, r_ld_beat, r_ld_len;
   logic [2:0]  r_size;
   logic [1:0]  r_burst, r_resp_q;
   logic        ar_rdy_q, r_vld_q, r_last_q, r_load, ar_hs, r_hs;

   w_state_t    w_state, w_nxt;
   logic [3:0]  w_id_q;
   logic [31:0] w_addr;
   logic [7:0]  w_len, w_beat;
   logic [2:0]  w_size;
   logic [1:0]  w_burst, b_resp_q;
   logic        aw_rdy_q, w_rdy_q, b_vld_q, w_err, w_beat_err, w_end;
   logic        aw_hs, w_hs, b_hs;

`ifdef C7B_AXI_SLV_STALL_EN
   logic [15:0] lfsr;
   logic        stall, r_shown, b_shown;
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr    <= 16'hACE1;
         r_shown <= 1'b0;
         b_shown <= 1'b0;
      end else begin
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         r_shown <= s_r_valid & ~s_r_ready;
         b_shown <= s_b_valid & ~s_b_ready;
      end
   end
   assign stall      = (lfsr[1:0] == 2'b00);
   assign s_ar_ready = ar_rdy_q & ~stall;
   assign s_aw_ready = aw_rdy_q & ~stall;
   assign s_w_ready  = w_rdy_q & ~stall;
   // a valid already on the bus stays up until it is taken
   assign s_r_valid  = r_vld_q & (r_shown | ~stall);
   assign s_b_valid  = b_vld_q & (b_shown | ~stall);
`else
   assign s_ar_ready = ar_rdy_q;
   assign s_aw_ready = aw_rdy_q;
   assign s_w_ready  = w_rdy_q;
   assign s_r_valid  = r_vld_q;
   assign s_b_valid  = b_vld_q;
`endif

   assign s_r_id   = r_id_q;
   assign s_r_data = r_data_q;
   assign s_r_resp = r_resp_q;
   assign s_r_last = r_last_q;
   assign s_b_id   = w_id_q;
   assign s_b_resp = b_resp_q;

   assign ar_hs = s_ar_valid & s_ar_ready;
   assign r_hs  = s_r_valid & s_r_ready;
   assign aw_hs = s_aw_valid & s_aw_ready;
   assign w_hs  = s_w_valid & s_w_ready;
   assign b_hs  = s_b_valid & s_b_ready;

   always_comb begin
      r_nxt     = r_state;
      r_load    = 1'b0;
      r_ld_addr = r_addr;
      r_ld_beat = r_beat;
      r_ld_len  = r_len;
      unique case (r_state)
         R_IDLE: if (ar_hs) begin
            if (RD_LATENCY <= 1) begin
               r_nxt     = R_DATA;
               r_load    = 1'b1;
               r_ld_addr = s_ar_addr;
               r_ld_beat = '0;
               r_ld_len  = s_ar_len;
            end else begin
               r_nxt = R_WAIT;
            end
         end
         R_WAIT: if (r_lat <= 8'd1) begin
            r_nxt  = R_DATA;
            r_load = 1'b1;
         end
         R_DATA: if (r_hs) begin
            if (r_beat == r_len) begin
               r_nxt = R_IDLE;
            end else begin
               r_load    = 1'b1;
               r_ld_addr = next_addr(r_addr, r_len, r_size, r_burst);
               r_ld_beat = r_beat + 8'd1;
            end
         end
         default: r_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= R_IDLE;
         ar_rdy_q <= 1'b0;
         r_vld_q  <= 1'b0;
         r_last_q <= 1'b0;
         r_data_q <= '0;
         r_resp_q <= '0;
         r_id_q   <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_size   <= '0;
         r_burst  <= '0;
         r_beat   <= '0;
         r_lat    <= '0;
      end else begin
         r_state  <= r_nxt;
         ar_rdy_q <= (r_nxt == R_IDLE);
         if (ar_hs) begin
            r_id_q  <= s_ar_id;
            r_addr  <= s_ar_addr;
            r_len   <= s_ar_len;
            r_size  <= s_ar_size;
            r_burst <= s_ar_burst;
            r_beat  <= '0;
            r_lat   <= LAT_INIT;
         end else if (r_state == R_WAIT && r_lat != 8'd0) begin
            r_lat <= r_lat - 8'd1;
         end
         if (r_load) begin
            r_addr   <= r_ld_addr;
            r_beat   <= r_ld_beat;
            r_vld_q  <= 1'b1;
            r_data_q <= in_range(r_ld_addr) ? mem[r_ld_addr[AW+1:2]] : '0;
            r_resp_q <= in_range(r_ld_addr) ? 2'b00 : 2'b10;
            r_last_q <= (r_ld_beat == r_ld_len);
         end else if (r_hs) begin
            r_vld_q  <= 1'b0;
            r_last_q <= 1'b0;
         end
      end
   end

   assign w_end      = (w_beat == w_len);
   assign w_beat_err = ~in_range(w_addr) | (s_w_last != w_end);

   always_comb begin
      w_nxt = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_hs) w_nxt = W_DATA;
         W_DATA:  if (w_hs && w_end) w_nxt = W_RESP;
         W_RESP:  if (b_hs) w_nxt = W_IDLE;
         default: w_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state  <= W_IDLE;
         aw_rdy_q <= 1'b0;
         w_rdy_q  <= 1'b0;
         b_vld_q  <= 1'b0;
         b_resp_q <= '0;
         w_id_q   <= '0;
         w_addr   <= '0;
         w_len    <= '0;
         w_size   <= '0;
         w_burst  <= '0;
         w_beat   <= '0;
         w_err    <= 1'b0;
      end else begin
         w_state  <= w_nxt;
         aw_rdy_q <= (w_nxt == W_IDLE);
         w_rdy_q  <= (w_nxt == W_DATA);
         b_vld_q  <= (w_nxt == W_RESP);
         if (aw_hs) begin
            w_id_q  <= s_aw_id;
            w_addr  <= s_aw_addr;
            w_len   <= s_aw_len;
            w_size  <= s_aw_size;
            w_burst <= s_aw_burst;
            w_beat  <= '0;
            w_err   <= 1'b0;
         end else if (w_hs) begin
            w_err <= w_err | w_beat_err;
            if (w_end) begin
               b_resp_q <= (w_err | w_beat_err) ? 2'b10 : 2'b00;
            end else begin
               w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
               w_beat <= w_beat + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_state == W_DATA && w_hs && in_range(w_addr)) begin
         for (int i = 0; i < 4; i++)
            if (s_w_strb[i])
               mem[w_addr[AW+1:2]][8*i +: 8] <= s_w_data[8*i +: 8];
      end
   end
endmodule

// File: doc/c7b_axi_sram_slave.md
Name: c7b_axi_sram_slave

Overview:
- AXI4 responder (slave) backed by an on-chip word-addressed SRAM array; the counterpart of the BIU's AXI initiator port.
- Used as the memory model in the core-level bench and as tightly-coupled RAM on FPGA builds.
- Accepts AR/R and AW/W/B traffic from the BIU: 4-bit IDs, 32-bit data, FIXED/INCR/WRAP bursts up to 16 beats.
- Read and write paths run independently, each with one outstanding transaction.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2); byte address range is 0 to DEPTH_WORDS*4-1.
- RD_LATENCY, 2, cycles from the AR handshake to the first r_valid (minimum 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_ar_valid  in  1  read address valid
- s_ar_ready  out  1  read address ready
- s_ar_id  in  4  read ID
- s_ar_addr  in  32  read byte address
- s_ar_len  in  8  beats-1 (0..15 legal)
- s_ar_size  in  3  bytes/beat log2 (0..2)
- s_ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_r_valid  out  1  read data valid
- s_r_ready  in  1  read data ready
- s_r_id  out  4  echoed s_ar_id
- s_r_data  out  32  read data
- s_r_resp  out  2  00 OKAY, 10 SLVERR
- s_r_last  out  1  final beat
- s_aw_valid / s_aw_ready / s_aw_id / s_aw_addr / s_aw_len / s_aw_size / s_aw_burst  in/out/in/in/in/in/in  1/1/4/32/8/3/2  write address channel, same encoding as AR
- s_w_valid  in  1  write data valid
- s_w_ready  out  1  write data ready
- s_w_data  in  32  write data
- s_w_strb  in  4  byte enables
- s_w_last  in  1  final beat flag from the initiator
- s_b_valid  out  1  write response valid
- s_b_ready  in  1  write response ready
- s_b_id  out  4  echoed s_aw_id
- s_b_resp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset: all outputs are registered and 0 while reset is high; array contents are not cleared. s_ar_ready and s_aw_ready rise the first cycle after reset falls.
- Reset mid-burst aborts the burst with no further beats or B response.
- Read FSM states: R_IDLE (s_ar_ready=1) -> on AR handshake latch id/addr/len/size/burst, clear beat_cnt, load lat_cnt=RD_LATENCY-1 -> R_WAIT.
- R_WAIT counts down; at 0, registers beat data and moves to R_DATA (s_r_valid=1). With RD_LATENCY=1, R_WAIT lasts 0 extra cycles: r_valid appears the cycle after AR is accepted.
- R_DATA holds r_data/r_resp/r_last/r_id stable while r_valid & ~r_ready. On handshake: if beat_cnt==len go to R_IDLE (s_ar_ready back the next cycle); else advance the address and present the next beat on the following cycle (1 beat/cycle when r_ready is held high).
- s_r_last = (beat_cnt==len) while r_valid.
- Address update per beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: the low bits within a (len+1)<<size boundary increment and wrap. WRAP with len not in {1,3,7,15} is treated as INCR.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Any beat with addr >= DEPTH_WORDS*4 returns r_data=0 and r_resp=10; other beats return OKAY.
- Write FSM:
  - W_IDLE (s_aw_ready=1) -> on AW handshake latch fields -> W_DATA.
  - W_DATA (s_w_ready=1): each W handshake writes the bytes enabled by s_w_strb. Out-of-range beats do not write and set the error flag. Beats where s_w_last != (beat_cnt==len) set the error flag.
  - The burst ends on the handshake where beat_cnt==len, going to W_RESP.
  - W_RESP: s_b_valid=1, b_id=latched id, b_resp=10 if the error flag is set, else 00. Held until s_b_ready, then -> W_IDLE.
- s_w_ready is low in W_IDLE: W data presented before AW is accepted waits.
- Read/write collision on the same word in the same cycle: the read beat registers the pre-write (old) value.
- len > 15 is handled as INCR with its full count; the 8-bit beat counter never wraps.

Optional Feature:
- Macro C7B_AXI_SLV_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reset to seed) gates s_ar_ready, s_aw_ready and s_w_ready, and delays s_r_valid/s_b_valid assertion. Each of these is suppressed in any cycle where LFSR[1:0]==2'b00. Once asserted, a valid is never withdrawn before its handshake. Used for BIU back-pressure stress.
- Undefined: no LFSR logic; timing is exactly as in Behaviour.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; s_ar_ready=s_aw_ready=1 the next cycle.
- AW addr 0x100 len 0 size 2 INCR, W data 0xDEADBEEF strb 0xF last 1; then AR addr 0x100 len 0, RD_LATENCY=2 -> b_resp 00; r_valid 2 cycles after AR handshake, r_data 0xDEADBEEF, r_last 1, r_id equal to ar_id.
- INCR write len 3 at 0x200 with data 1,2,3,4; WRAP read addr 0x208 len 3 -> r_data order 3,4,1,2, r_last on the 4th beat only.
- Write strb 0x3 data 0x11112222 over word 0xFFFFFFFF, then read -> 0xFFFF2222.
- AR addr DEPTH_WORDS*4 len 1 -> two beats, data 0, resp 10. AW len 1 with w_last on the first beat -> b_resp 10.
- r_ready held low 5 cycles on beat 0 of a len-1 read -> r_data/r_valid stable throughout; second beat follows the cycle after the handshake.
